// File: rtl/seq_mul_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  // Counter must hold values 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mul_cond_neg.sv
// Conditional two's-complement negation: y = neg ? -x : x, wrapping at W bits.
module seq_mul_cond_neg #(
  parameter int unsigned W = 8
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = neg ? -x : x;

endmodule

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: one partial product per cycle, valid/ready on both
// sides, runtime signed/unsigned mode operating on operand magnitudes.
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     p_q, p_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;

  logic              eff_signed;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [WIDTH:0]    sum;
  logic [PW-1:0]     acc_next;
  logic [PW-1:0]     p_signed;

  // With SIGNED_EN=0 this folds to 0 and the negation logic collapses.
  assign eff_signed = SIGNED_EN & signed_mode;

  seq_mul_cond_neg #(.W(WIDTH)) u_mag_a (
    .neg (eff_signed & a[WIDTH-1]),
    .x   (a),
    .y   (mag_a)
  );

  seq_mul_cond_neg #(.W(WIDTH)) u_mag_b (
    .neg (eff_signed & b[WIDTH-1]),
    .x   (b),
    .y   (mag_b)
  );

  // Add into the upper half with a carry bit, then shift the whole accumulator right.
  always_comb begin
    sum      = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, mcand_q & {WIDTH{mplier_q[0]}}};
    acc_next = {sum, acc_q[WIDTH-1:1]};
  end

  seq_mul_cond_neg #(.W(PW)) u_neg_p (
    .neg (neg_q),
    .x   (acc_next),
    .y   (p_signed)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    p_d       = p_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d  = StCalc;
          mcand_d  = mag_a;
          mplier_d = mag_b;
          neg_d    = eff_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      StCalc: begin
        busy     = 1'b1;
        acc_d    = acc_next;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntOne;
        if (cnt_q == CntLast) begin
          state_d = StDone;
          p_d     = p_signed;
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul: 8-bit signed-capable, 4-bit, and 8-bit unsigned-only instances.
module tb_seq_mul;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // sel 0: WIDTH=8 SIGNED_EN=1, sel 1: WIDTH=4 SIGNED_EN=1, sel 2: WIDTH=8 SIGNED_EN=0
  logic iv0 = 0, ir0, sm0 = 0, ov0, or0 = 0, busy0;
  logic [7:0] a0 = 0, b0 = 0;
  logic [15:0] p0;
  logic iv1 = 0, ir1, sm1 = 0, ov1, or1 = 0, busy1;
  logic [3:0] a1 = 0, b1 = 0;
  logic [7:0] p1;
  logic iv2 = 0, ir2, sm2 = 0, ov2, or2 = 0, busy2;
  logic [7:0] a2 = 0, b2 = 0;
  logic [15:0] p2;

  seq_mul #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .signed_mode(sm0), .out_valid(ov0), .out_ready(or0), .p(p0), .busy(busy0)
  );
  seq_mul #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .signed_mode(sm1), .out_valid(ov1), .out_ready(or1), .p(p1), .busy(busy1)
  );
  seq_mul #(.WIDTH(8), .SIGNED_EN(1'b0)) dutu (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .signed_mode(sm2), .out_valid(ov2), .out_ready(or2), .p(p2), .busy(busy2)
  );

  int n_vec = 0;
  int n_err = 0;
  longint exp_q[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference product computed from plain integer arithmetic.
  function automatic longint model(longint a, longint b, int w, bit sm);
    longint mask = (longint'(1) << (2 * w)) - 1;
    if (sm) begin
      if (a[w-1]) a = a - (longint'(1) << w);
      if (b[w-1]) b = b - (longint'(1) << w);
    end
    return (a * b) & mask;
  endfunction

  function automatic bit f_in_ready(int sel);
    return (sel == 0) ? ir0 : (sel == 1) ? ir1 : ir2;
  endfunction
  function automatic bit f_out_valid(int sel);
    return (sel == 0) ? ov0 : (sel == 1) ? ov1 : ov2;
  endfunction
  function automatic bit f_busy(int sel);
    return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  endfunction
  function automatic longint f_p(int sel);
    return (sel == 0) ? longint'(p0) : (sel == 1) ? longint'(p1) : longint'(p2);
  endfunction

  task automatic drive(input int sel, input longint a, input longint b, input bit sm,
                       input bit v);
    case (sel)
      0: begin a0 = a[7:0]; b0 = b[7:0]; sm0 = sm; iv0 = v; end
      1: begin a1 = a[3:0]; b1 = b[3:0]; sm1 = sm; iv1 = v; end
      default: begin a2 = a[7:0]; b2 = b[7:0]; sm2 = sm; iv2 = v; end
    endcase
  endtask

  task automatic set_oready(input int sel, input bit v);
    case (sel)
      0: or0 = v;
      1: or1 = v;
      default: or2 = v;
    endcase
  endtask

  // Present one operand pair, push its expectation, and check the exact latency.
  task automatic issue(input int sel, input longint a, input longint b, input bit sm);
    int w = (sel == 1) ? 4 : 8;
    bit eff = (sel == 2) ? 1'b0 : sm;
    int n = 0;
    while (!f_in_ready(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!f_in_ready(sel)) check("in_ready_timeout", 0, 1);
    drive(sel, a, b, sm, 1'b1);
    exp_q.push_back(model(a, b, w, eff));
    @(negedge clk);
    drive(sel, a, b, sm, 1'b0);
    for (int k = 1; k <= w; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_in_calc", f_busy(sel), 1);
      if (k == w - 1) begin
        check("out_valid_early", f_out_valid(sel), 0);
        check("in_ready_calc", f_in_ready(sel), 0);
      end
      if (k == w) check("out_valid_latency", f_out_valid(sel), 1);
    end
  endtask

  // Wait for a product, hold back-pressure for 'hold' cycles, then handshake and score.
  task automatic collect(input int sel, input int hold);
    longint p_seen;
    longint e;
    int n = 0;
    while (!f_out_valid(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!f_out_valid(sel)) check("out_valid_timeout", 0, 1);
    p_seen = f_p(sel);
    set_oready(sel, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("p_stable", f_p(sel), p_seen);
      check("out_valid_held", f_out_valid(sel), 1);
      check("in_ready_done", f_in_ready(sel), 0);
    end
    set_oready(sel, 1'b1);
    @(negedge clk);
    set_oready(sel, 1'b0);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("product", p_seen, e);
    end
    check("idle_after_hs", f_in_ready(sel), 1);
    check("out_valid_after_hs", f_out_valid(sel), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", ir0, 1);
    check("rst_out_valid", ov0, 0);
    check("rst_busy", busy0, 0);
    check("rst_p", p0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 255, 255, 0);
    collect(0, 0);
    issue(0, 8'h80, 8'h80, 1);
    collect(0, 0);
    // out_ready high across the CALC->DONE edge must not complete the handshake early
    set_oready(0, 1'b1);
    issue(0, 8'hFD, 5, 1);
    collect(0, 0);
    issue(0, 0, 0, 0);
    collect(0, 1);

    // Back-pressure with new operands waiting on in_valid
    issue(0, 8'h12, 8'h34, 0);
    drive(0, 8'hAA, 8'h55, 1'b1, 1'b1);
    collect(0, 5);
    drive(0, 8'hAA, 8'h55, 1'b1, 1'b0);
    @(negedge clk);
    check("no_queued_accept", busy0, 0);

    // Reset during the third CALC cycle
    drive(0, 200, 100, 1'b0, 1'b1);
    @(negedge clk);
    drive(0, 200, 100, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("busy_before_abort", busy0, 1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", ov0, 0);
    check("abort_busy", busy0, 0);
    check("abort_p", p0, 0);
    check("abort_in_ready", ir0, 1);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 3, 4, 0);
    collect(0, 0);

    for (int i = 0; i < 10; i++) begin
      issue(0, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      collect(0, $urandom_range(0, 3));
    end

    issue(1, 15, 15, 0);
    collect(1, 0);
    issue(1, 4'h8, 4'h7, 1);
    collect(1, 0);
    issue(1, 4'h8, 4'h8, 1);
    collect(1, 2);

    issue(2, 8'hFF, 8'h02, 1);
    collect(2, 0);
    issue(2, 8'h80, 8'h80, 1);
    collect(2, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
